// File: rtl/sram_bist_pkg.sv
// Shared March C- definitions: element enum, op encoding and the march table.
package sram_bist_pkg;

    localparam int unsigned NUM_ELEMS = 6;
    localparam int unsigned ELEM_W    = 3;

    typedef enum logic [ELEM_W-1:0] {
        ELEM_M0 = 3'd0,
        ELEM_M1 = 3'd1,
        ELEM_M2 = 3'd2,
        ELEM_M3 = 3'd3,
        ELEM_M4 = 3'd4,
        ELEM_M5 = 3'd5
    } march_elem_e;

    typedef enum logic {
        KIND_READ  = 1'b0,
        KIND_WRITE = 1'b1
    } op_kind_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } march_dir_e;

    // pol=0 selects the background pattern, pol=1 its complement
    typedef struct packed {
        op_kind_e kind;
        logic     pol;
    } march_op_t;

    typedef struct packed {
        march_dir_e dir;
        logic       two_ops;
        march_op_t  op0;
        march_op_t  op1;
    } march_elem_t;

    localparam march_op_t OP_W0 = '{kind: KIND_WRITE, pol: 1'b0};
    localparam march_op_t OP_W1 = '{kind: KIND_WRITE, pol: 1'b1};
    localparam march_op_t OP_R0 = '{kind: KIND_READ,  pol: 1'b0};
    localparam march_op_t OP_R1 = '{kind: KIND_READ,  pol: 1'b1};

    localparam march_elem_e LAST_ELEM = march_elem_e'(ELEM_W'(NUM_ELEMS - 1));

    function automatic march_elem_t march_table(input march_elem_e elem);
        march_elem_t t;
        t = '{DIR_UP, 1'b0, OP_W0, OP_W0};
        case (elem)
            ELEM_M0: t = '{DIR_UP,   1'b0, OP_W0, OP_W0};
            ELEM_M1: t = '{DIR_UP,   1'b1, OP_R0, OP_W1};
            ELEM_M2: t = '{DIR_UP,   1'b1, OP_R1, OP_W0};
            ELEM_M3: t = '{DIR_DOWN, 1'b1, OP_R0, OP_W1};
            ELEM_M4: t = '{DIR_DOWN, 1'b1, OP_R1, OP_W0};
            ELEM_M5: t = '{DIR_DOWN, 1'b0, OP_R0, OP_R0};
            default: t = '{DIR_UP,   1'b0, OP_W0, OP_W0};
        endcase
        return t;
    endfunction

    function automatic march_elem_e next_elem(input march_elem_e elem);
        return march_elem_e'(ELEM_W'(elem) + ELEM_W'(1));
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-compare pipeline: delays expected data to the SRAM read latency,
// compares with dout0 and records the first failure plus a saturating count.
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  clear_i,
    input  logic                  flush_i,
    input  logic                  rd_vld_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [DATA_WIDTH-1:0] dout0_i,
    output logic                  mismatch_c,
    output logic [7:0]            err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o
);

    localparam int unsigned LAST  = READ_LATENCY - 1;
    localparam int unsigned CNT_W = 8;

    logic                  vld_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] exp_q  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_q [READ_LATENCY];

    logic [CNT_W-1:0]      err_q, err_d;
    logic [ADDR_WIDTH-1:0] fa_q, fa_d;
    logic [DATA_WIDTH-1:0] fd_q, fd_d;

    // Expected-data delay line; a flush drops reads still in flight
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                vld_q[i]  <= 1'b0;
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= rd_vld_i && !flush_i;
            exp_q[0]  <= rd_exp_i;
            addr_q[0] <= rd_addr_i;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i]  <= vld_q[i-1] && !flush_i;
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign mismatch_c = vld_q[LAST] && (dout0_i != exp_q[LAST]);

    // A zero count doubles as "no failure captured yet"
    always_comb begin
        err_d = err_q;
        fa_d  = fa_q;
        fd_d  = fd_q;
        if (clear_i) begin
            err_d = '0;
            fa_d  = '0;
            fd_d  = '0;
        end else if (mismatch_c) begin
            if (err_q == '0) begin
                fa_d = addr_q[LAST];
                fd_d = dout0_i;
            end
            if (err_q != '1) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            err_q <= '0;
            fa_q  <= '0;
            fd_q  <= '0;
        end else begin
            err_q <= err_d;
            fa_q  <= fa_d;
            fd_q  <= fd_d;
        end
    end

    assign err_count_o = err_q;
    assign fail_addr_o = fa_q;
    assign fail_data_o = fd_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- memory BIST controller: sequences 1280 SRAM ops per run and
// reports pass/fail through the read-compare pipeline.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 7,
    parameter int unsigned           READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN   = DATA_WIDTH'(32'h5555_5555)
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned          DRAIN_W    = 2;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);

    logic [1:0]            state_q, state_d;
    march_elem_e           elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic                  op_q, op_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;

    logic                  issue_c;
    logic                  clear_c;
    logic                  flush_c;
    logic                  mismatch_c;
    march_elem_t           cur_c;
    march_elem_t           nxt_c;
    march_op_t             sel_c;

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        step_d  = step_q;
        op_d    = op_q;
        drain_d = drain_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        issue_c = 1'b0;
        clear_c = 1'b0;
        flush_c = 1'b0;
        csb0_d  = 1'b1;
        web0_d  = 1'b1;
        addr0_d = '0;
        din0_d  = '0;
        exp_d   = '0;
        cur_c   = march_table(elem_q);
        nxt_c   = '0;
        sel_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_RUN;
                    elem_d  = ELEM_M0;
                    step_d  = '0;
                    op_d    = 1'b0;
                    pass_d  = 1'b0;
                    clear_c = 1'b1;
                    issue_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush_c = 1'b1;
                end else if (op_q != cur_c.two_ops) begin
                    op_d    = 1'b1;
                    issue_c = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (step_q != '1) begin
                        step_d  = step_q + ADDR_WIDTH'(1);
                        issue_c = 1'b1;
                    end else if (elem_q != LAST_ELEM) begin
                        step_d  = '0;
                        elem_d  = next_elem(elem_q);
                        issue_c = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush_c = 1'b1;
                end else if (drain_q == DRAIN_LAST) begin
                    // The final read is compared in this cycle, so fold it in
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_count == '0) && !mismatch_c;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);

        // Registered SRAM command for the op selected by the next counters
        if (issue_c) begin
            nxt_c   = march_table(elem_d);
            sel_c   = op_d ? nxt_c.op1 : nxt_c.op0;
            csb0_d  = 1'b0;
            web0_d  = (sel_c.kind == KIND_READ);
            addr0_d = (nxt_c.dir == DIR_DOWN) ? ~step_d : step_d;
            exp_d   = sel_c.pol ? ~BG_PATTERN : BG_PATTERN;
            din0_d  = (sel_c.kind == KIND_WRITE) ? exp_d : '0;
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= ST_IDLE;
            elem_q  <= ELEM_M0;
            step_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            csb0_q  <= 1'b1;
            web0_q  <= 1'b1;
            addr0_q <= '0;
            din0_q  <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            step_q  <= step_d;
            op_q    <= op_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            csb0_q  <= csb0_d;
            web0_q  <= web0_d;
            addr0_q <= addr0_d;
            din0_q  <= din0_d;
            exp_q   <= exp_d;
        end
    end

    sram_bist_cmp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_cmp (
        .clk0       (clk0),
        .rst0_n     (rst0_n),
        .clear_i    (clear_c),
        .flush_i    (flush_c || clear_c),
        .rd_vld_i   (!csb0_q && web0_q),
        .rd_addr_i  (addr0_q),
        .rd_exp_i   (exp_q),
        .dout0_i    (dout0),
        .mismatch_c (mismatch_c),
        .err_count_o(err_count),
        .fail_addr_o(fail_addr),
        .fail_data_o(fail_data)
    );

    assign busy  = busy_q;
    assign done  = done_q;
    assign pass  = pass_q;
    assign csb0  = csb0_q;
    assign web0  = web0_q;
    assign addr0 = addr0_q;
    assign din0  = din0_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Randomized scoreboard bench for sram_march_bist with a faulty-SRAM model.
module tb_sram_march_bist;

    localparam int          DW    = 32;
    localparam int          AW    = 7;
    localparam int          RL    = 1;
    localparam int          DEPTH = 128;
    localparam int          NOPS  = 1280;
    localparam logic [31:0] BG    = 32'h5555_5555;

    // March C- as plain lists: op code 0=w0 1=w1 2=r0 3=r1
    localparam int EL_N   [6]    = '{1, 2, 2, 2, 2, 1};
    localparam int EL_DN  [6]    = '{0, 0, 0, 1, 1, 1};
    localparam int EL_OP  [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};

    typedef struct packed {
        logic          web;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct {
        bit            pass;
        int unsigned   errs;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } res_t;

    logic          clk0;
    logic          rst0_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] and_m   [DEPTH];
    logic [DW-1:0] or_m    [DEPTH];
    logic [DW-1:0] rd_pipe [RL];

    op_t  exp_ops[$];
    res_t exp_res[$];

    int unsigned n_checks;
    int unsigned n_pass;
    bit          last_pass;
    int unsigned last_errs;
    int unsigned bcnt;

    sram_march_bist #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .BG_PATTERN  (BG)
    ) dut (
        .clk0     (clk0),
        .rst0_n   (rst0_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .csb0     (csb0),
        .web0     (web0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // SRAM with per-cell stuck-at masks applied on read
    always @(posedge clk0) begin
        if (!csb0 && !web0) mem[addr0] <= din0;
        if (!csb0 && web0) rd_pipe[0] <= (mem[addr0] & and_m[addr0]) | or_m[addr0];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dout0 = rd_pipe[RL-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    endtask

    // Reference: walk March C- over an ideal array with the same fault masks
    task automatic plan_run();
        logic [DW-1:0] ideal [DEPTH];
        logic [DW-1:0] data, got;
        int            a, c;
        int unsigned   cnt;
        res_t          r;
        op_t           o;
        r = '{1'b1, 0, '0, '0};
        cnt = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (EL_DN[e] != 0) ? (DEPTH - 1 - k) : k;
                for (int j = 0; j < EL_N[e]; j++) begin
                    c = EL_OP[e][j];
                    data = ((c & 1) != 0) ? ~BG : BG;
                    if (c >= 2) begin
                        got = (ideal[a] & and_m[a]) | or_m[a];
                        if (got != data) begin
                            if (cnt == 0) begin
                                r.fa = AW'(a);
                                r.fd = got;
                            end
                            cnt++;
                        end
                        o = '{1'b1, AW'(a), '0};
                    end else begin
                        ideal[a] = data;
                        o = '{1'b0, AW'(a), data};
                    end
                    exp_ops.push_back(o);
                end
            end
        end
        r.errs = (cnt > 255) ? 255 : cnt;
        r.pass = (cnt == 0);
        last_pass = r.pass;
        last_errs = r.errs;
        exp_res.push_back(r);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            and_m[i] = '1;
            or_m[i]  = '0;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk0);
        start = 1'b1;
        @(negedge clk0);
        start = 1'b0;
    endtask

    task automatic run_full(input bit noisy);
        bit seen;
        plan_run();
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk0);
            start = (noisy && busy && $urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk0);
        chk("done_one_cycle", 64'(done), 64'd0);
        repeat (3) @(negedge clk0);
        chk("pass_held", 64'(pass), 64'(last_pass));
        chk("err_held", 64'(err_count), 64'(last_errs));
    endtask

    // Monitor: pops expected ops and results as the DUT presents them
    always @(negedge clk0) begin : mon
        op_t  e;
        res_t r;
        if (rst0_n) begin
            if (busy && !csb0) begin
                chk("op_pending", 64'(exp_ops.size() > 0), 64'd1);
                if (exp_ops.size() > 0) begin
                    e = exp_ops.pop_front();
                    chk("op_web", 64'(web0), 64'(e.web));
                    chk("op_addr", 64'(addr0), 64'(e.addr));
                    if (!e.web) chk("op_din", 64'(din0), 64'(e.din));
                end
            end else begin
                chk("idle_bus", 64'({csb0, web0, addr0, din0}), 64'({1'b1, 1'b1, 7'd0, 32'd0}));
            end
            if (busy) begin
                bcnt++;
            end else begin
                if (done) begin
                    chk("done_expected", 64'(exp_res.size() > 0), 64'd1);
                    chk("busy_len", 64'(bcnt), 64'(NOPS + RL));
                    if (exp_res.size() > 0) begin
                        r = exp_res.pop_front();
                        chk("pass", 64'(pass), 64'(r.pass));
                        chk("err_count", 64'(err_count), 64'(r.errs));
                        chk("fail_addr", 64'(fail_addr), 64'(r.fa));
                        chk("fail_data", 64'(fail_data), 64'(r.fd));
                    end
                    chk("ops_drained", 64'(exp_ops.size()), 64'd0);
                end
                bcnt = 0;
            end
        end
    end

    initial begin : main
        bit seen;
        int nf, a, b;
        n_checks = 0;
        n_pass   = 0;
        bcnt     = 0;
        start    = 1'b0;
        abort    = 1'b0;
        rst0_n   = 1'b1;
        clear_faults();
        #2 rst0_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_fail_addr", 64'(fail_addr), 64'd0);
        chk("rst_fail_data", 64'(fail_data), 64'd0);
        chk("rst_bus", 64'({csb0, web0, addr0, din0}), 64'({1'b1, 1'b1, 7'd0, 32'd0}));
        repeat (3) @(negedge clk0);
        rst0_n = 1'b1;
        repeat (2) @(negedge clk0);

        run_full(1'b1);

        or_m[10][0] = 1'b1;
        run_full(1'b0);
        clear_faults();

        for (int t = 0; t < 4; t++) begin
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, DEPTH - 1);
                b = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) or_m[a][b] = 1'b1;
                else and_m[a][b] = 1'b0;
            end
            run_full(t[0]);
            clear_faults();
        end

        for (int i = 0; i < DEPTH; i++) and_m[i] = '0;
        run_full(1'b0);
        clear_faults();

        // Abort 500 cycles into a run
        plan_run();
        start_pulse();
        repeat (499) @(negedge clk0);
        abort = 1'b1;
        @(posedge clk0);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_csb0", 64'(csb0), 64'd1);
        chk("abort_pass", 64'(pass), 64'd0);
        exp_ops.delete();
        exp_res.delete();
        @(negedge clk0);
        abort = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1400; i++) begin
            @(negedge clk0);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_pass_low", 64'(pass), 64'd0);

        // Asynchronous reset 700 cycles into a noisy run
        plan_run();
        start_pulse();
        for (int i = 0; i < 699; i++) begin
            @(negedge clk0);
            start = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        @(posedge clk0);
        #2 rst0_n = 1'b0;
        #1;
        chk("arst_csb0", 64'(csb0), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_err", 64'(err_count), 64'd0);
        exp_ops.delete();
        exp_res.delete();
        @(negedge clk0);
        start = 1'b1;
        @(negedge clk0);
        start  = 1'b0;
        rst0_n = 1'b1;
        repeat (5) @(negedge clk0);
        chk("no_resume_busy", 64'(busy), 64'd0);
        chk("no_resume_csb0", 64'(csb0), 64'd1);

        run_full(1'b1);
        chk("fresh_pass", 64'(pass), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
